pipeline_ctrl: RTL
==================

Name: pipeline_ctrl

Overview:
Central pipeline controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Drives the shared stall vector (stall_t) and the flush pulse consumed by every inter-stage register (if_id, id_ex, ex_mem, mem_wb).
- Receives stall requests and the committed exception/ERET redirect from MEM.
- Sequences the PC redirect into a fetch unit that may have a fetch outstanding.
- Keeps a stall-cycle performance counter.

Parameters:
CNT_WIDTH, 32, width of stall_cycles counter
REDIRECT_HOLD_MAX, 15, cycles a pending redirect may wait for ack before assert_timeout fires (debug only)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
stallreq_if  input  1  IF stage cannot advance (icache miss)
stallreq_id  input  1  ID hazard (load-use, branch operand not ready)
stallreq_ex  input  1  EX multi-cycle op (div, mult-acc, FPU)
stallreq_mem  input  1  MEM cannot complete (dcache miss, uncached access)
except_req  input  1  MEM commits an exception or ERET this cycle
except_pc  input  32  target PC for except_req (exception vector or EPC)
if_busy  input  1  fetch unit has an outstanding bus transaction
redirect_ack  input  1  fetch unit accepted redirect_pc
stall  output  $bits(stall_t)  {stall_if, stall_id, stall_ex, stall_mem, stall_wb}
flush  output  1  kill all inter-stage registers this cycle
redirect_valid  output  1  redirect_pc is valid, held until ack
redirect_pc  output  32  new fetch PC
stall_cycles  output  CNT_WIDTH  count of cycles with stall.stall_if=1
assert_timeout  output  1  sticky; redirect waited > REDIRECT_HOLD_MAX cycles

Behaviour:
- Reset (synchronous): state=RUN; stall=0, flush=0, redirect_valid=0, redirect_pc=0, stall_cycles=0, assert_timeout=0, hold counter=0.
- Stall vector (combinational from inputs and state): request from stage k stalls stages IF..k and leaves k+1 free, so downstream registers insert a bubble.
  - Priority: mem > ex > id > if.
  - mem -> {1,1,1,1,0}; ex -> {1,1,1,0,0}; id -> {1,1,0,0,0}; if -> {1,0,0,0,0}; none -> 0.
  - stall_wb is always 0.
- States: RUN, REDIRECT.
- RUN:
  - except_req=1 with stallreq_mem=1: ignored; MEM re-presents it next cycle.
  - except_req=1 with stallreq_mem=0:
    - flush=1 in the same cycle (combinational); stall forced to 0 that cycle.
    - Registered: redirect_pc<=except_pc, redirect_valid<=1, state<=REDIRECT.
- REDIRECT:
  - Outputs: flush=0, stall={1,0,0,0,0}, so IF holds and downstream drains bubbles.
  - redirect_valid stays 1 and redirect_pc stays stable until the handshake completes.
  - Handshake completes on a cycle where redirect_ack=1 and if_busy=0. Next cycle: redirect_valid=0, state=RUN.
  - redirect_ack while if_busy=1 is not a completion; hold.
  - except_req in REDIRECT: ignored (pipeline is empty; any such request is spurious).
  - Hold counter: increments each REDIRECT cycle, saturating; clears on RUN entry. Exceeding REDIRECT_HOLD_MAX sets assert_timeout (sticky until rst).
- stall_cycles: +1 every cycle stall.stall_if=1 (including REDIRECT cycles); wraps modulo 2^CNT_WIDTH; flush alone does not count.
- Reset mid-REDIRECT: returns to RUN; pending redirect dropped; fetch unit restarts from its own reset PC.
- Single-cycle flush is guaranteed: flush is never 1 on two consecutive cycles.

Decomposition:
- Shared defines package (existing): stall_t, reset constants.
- Add to the package:
  - ctrlState_t enum {CTRL_RUN, CTRL_REDIRECT}
  - STALL_VEC_* localparam constants for the four stall patterns
- Sub-module: stall_encoder (purely combinational priority encoder from stallreq_* to stall_t). Keeps the FSM file focused on redirect sequencing.

Test Plan:
1. stallreq_ex=1 alone for 3 cycles -> stall={1,1,1,0,0} each cycle; stall_cycles goes 0->3; flush=0.
2. stallreq_id=1 and stallreq_mem=1 together -> stall={1,1,1,1,0} (mem wins).
3. except_req=1, except_pc=0xBFC00380, if_busy=0, redirect_ack=1 next cycle:
   - flush=1 for exactly 1 cycle.
   - redirect_valid=1 with pc 0xBFC00380 for 1 cycle, then RUN.
4. except_req with if_busy=1 for 4 cycles, redirect_ack held 1 throughout:
   - redirect_valid stays 1 for 5 cycles; stall={1,0,0,0,0} throughout.
   - Completes on the cycle if_busy drops.
5. except_req=1 with stallreq_mem=1 -> flush=0, state stays RUN; drop stallreq_mem next cycle -> flush=1.
6. Enter REDIRECT, hold redirect_ack=0 for 16 cycles -> assert_timeout=1 and stays 1; then assert rst -> all outputs 0, state RUN.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_pkg
// Brief  : Shared pipeline-control types. Defines the stall vector, the
//          controller state type, the canonical stall patterns and the
//          reset constants.
// Rev    : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

  // One bit per pipeline stage. stall_if is the most significant bit.
  typedef struct packed {
    logic stall_if;
    logic stall_id;
    logic stall_ex;
    logic stall_mem;
    logic stall_wb;
  } stall_t;

  typedef enum logic [0:0] {
    CTRL_RUN      = 1'b0,
    CTRL_REDIRECT = 1'b1
  } ctrlState_t;

  // A request from stage k freezes IF..k and leaves k+1 free, so a bubble
  // enters the register downstream of k.
  localparam stall_t STALL_VEC_NONE = stall_t'(5'b00000);
  localparam stall_t STALL_VEC_IF   = stall_t'(5'b10000);
  localparam stall_t STALL_VEC_ID   = stall_t'(5'b11000);
  localparam stall_t STALL_VEC_EX   = stall_t'(5'b11100);
  localparam stall_t STALL_VEC_MEM  = stall_t'(5'b11110);

  localparam ctrlState_t RST_STATE       = CTRL_RUN;
  localparam logic [31:0] RST_REDIRECT_PC = 32'h0000_0000;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_stall_encoder.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_stall_encoder
// Brief  : Combinational priority encoder from per-stage stall requests to
//          the shared stall vector. The deepest requesting stage wins.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_ctrl_stall_encoder
  import pipeline_ctrl_pkg::*;
(
  input  logic   stallreq_if_i,
  input  logic   stallreq_id_i,
  input  logic   stallreq_ex_i,
  input  logic   stallreq_mem_i,
  output stall_t stall_o
);

  // Priority mem > ex > id > if; stall_wb is never asserted.
  always_comb begin
    stall_o = STALL_VEC_NONE;
    if (stallreq_mem_i) begin
      stall_o = STALL_VEC_MEM;
    end else if (stallreq_ex_i) begin
      stall_o = STALL_VEC_EX;
    end else if (stallreq_id_i) begin
      stall_o = STALL_VEC_ID;
    end else if (stallreq_if_i) begin
      stall_o = STALL_VEC_IF;
    end
  end

endmodule : pipeline_ctrl_stall_encoder
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Central controller for the 5-stage pipeline. Produces the stall
//          vector and flush pulse, sequences exception/ERET redirects into
//          the fetch unit and counts IF stall cycles.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH         = 32,
  parameter int REDIRECT_HOLD_MAX = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallreq_if,
  input  logic                 stallreq_id,
  input  logic                 stallreq_ex,
  input  logic                 stallreq_mem,
  input  logic                 except_req,
  input  logic [31:0]          except_pc,
  input  logic                 if_busy,
  input  logic                 redirect_ack,
  output stall_t               stall,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic                 assert_timeout
);

  // Hold counter must reach MAX+1 so that "waited longer than MAX" is visible.
  localparam int HOLD_W = $clog2(REDIRECT_HOLD_MAX + 2);
  localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(REDIRECT_HOLD_MAX);
  localparam logic [HOLD_W-1:0] HOLD_SAT_C = HOLD_W'(REDIRECT_HOLD_MAX + 1);

  ctrlState_t           state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic                 timeout_q, timeout_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  stall_t               enc_stall;

  pipeline_ctrl_stall_encoder u_stall_encoder (
    .stallreq_if_i  (stallreq_if),
    .stallreq_id_i  (stallreq_id),
    .stallreq_ex_i  (stallreq_ex),
    .stallreq_mem_i (stallreq_mem),
    .stall_o        (enc_stall)
  );

  // Next-state and output decode for the redirect sequencer.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    timeout_d = timeout_q;
    flush     = 1'b0;
    stall     = enc_stall;
    case (state_q)
      CTRL_RUN: begin
        hold_d = '0;
        // An exception held up by a MEM stall is re-presented later, so only
        // an unstalled one is committed here.
        if (except_req && !stallreq_mem) begin
          flush   = 1'b1;
          stall   = STALL_VEC_NONE;
          pc_d    = except_pc;
          state_d = CTRL_REDIRECT;
        end
      end
      CTRL_REDIRECT: begin
        // IF holds the old PC while the rest of the pipe drains bubbles.
        stall = STALL_VEC_IF;
        if (hold_q != HOLD_SAT_C) begin
          hold_d = hold_q + 1'b1;
        end
        // hold_q counts earlier REDIRECT cycles; this one is number hold_q+1.
        if (hold_q >= HOLD_MAX_C) begin
          timeout_d = 1'b1;
        end
        // An ack while a fetch is still outstanding does not complete.
        if (redirect_ack && !if_busy) begin
          state_d = CTRL_RUN;
        end
      end
      default: begin
        state_d = CTRL_RUN;
      end
    endcase
  end

  // State, redirect target, hold counter, sticky timeout and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RST_STATE;
      pc_q      <= RST_REDIRECT_PC;
      hold_q    <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_q + CNT_WIDTH'(stall.stall_if);
    end
  end

  assign redirect_valid = (state_q == CTRL_REDIRECT);
  assign redirect_pc    = pc_q;
  assign stall_cycles   = cnt_q;
  assign assert_timeout = timeout_q;

endmodule : pipeline_ctrl
`default_nettype wire
